// File: rtl/hp_manager_if.sv
// Event and status bundle between the game-event logic (master) and the
// HP manager (slave); the status side also feeds the LED bar.
interface hp_manager_if #(
    parameter int HP_W  = 4,
    parameter int DMG_W = 2
);
    logic             DAMAGE;
    logic [DMG_W-1:0] DMG_AMT;
    logic             HEAL;
    logic             START;
    logic [HP_W-1:0]  OUT_HP;
    logic             DEAD;
    logic             INVULN;
    logic             HIT;

    modport master (
        output DAMAGE, DMG_AMT, HEAL, START,
        input  OUT_HP, DEAD, INVULN, HIT
    );

    modport slave (
        input  DAMAGE, DMG_AMT, HEAL, START,
        output OUT_HP, DEAD, INVULN, HIT
    );
endinterface

// File: rtl/hp_manager.sv
// Player hit-point register with saturating damage/heal, a timed
// post-hit invulnerability window and a latched death state.
module hp_manager #(
    parameter int HP_MAX     = 10,
    parameter int HP_W       = 4,
    parameter int DMG_W      = 2,
    parameter int INVULN_CYC = 25000000
) (
    input  logic         CLK,
    input  logic         RST,
    hp_manager_if.slave  bus
);

    localparam int CNT_W = (INVULN_CYC > 1) ? $clog2(INVULN_CYC) : 1;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t           state;
    logic [HP_W-1:0]  hp;
    logic [CNT_W-1:0] cnt;
    logic             dead_r;
    logic             invuln_r;
    logic             hit_r;
    logic             dmg_q;
    logic             heal_q;
    logic             start_q;
    logic             armed;

    logic             dmg_rise;
    logic             heal_rise;
    logic             start_rise;
    logic [HP_W-1:0]  amt_ext;
    logic [HP_W-1:0]  hp_max_c;

    // armed stays low for the first cycle after reset so inputs already
    // held high at release only load the history instead of firing events
    assign dmg_rise   = armed & bus.DAMAGE & ~dmg_q;
    assign heal_rise  = armed & bus.HEAL   & ~heal_q;
    assign start_rise = armed & bus.START  & ~start_q;
    assign amt_ext    = HP_W'(bus.DMG_AMT);
    assign hp_max_c   = HP_W'(HP_MAX);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ALIVE;
            hp       <= HP_W'(HP_MAX);
            cnt      <= '0;
            dead_r   <= 1'b0;
            invuln_r <= 1'b0;
            hit_r    <= 1'b0;
            dmg_q    <= 1'b0;
            heal_q   <= 1'b0;
            start_q  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            dmg_q   <= bus.DAMAGE;
            heal_q  <= bus.HEAL;
            start_q <= bus.START;
            armed   <= 1'b1;
            hit_r   <= 1'b0;

            if (start_rise) begin
                state    <= ALIVE;
                hp       <= hp_max_c;
                cnt      <= '0;
                dead_r   <= 1'b0;
                invuln_r <= 1'b0;
            end else begin
                case (state)
                    ALIVE: begin
                        if (dmg_rise) begin
                            if (amt_ext != '0) begin
                                hit_r <= 1'b1;
                                if (hp > amt_ext) begin
                                    hp       <= hp - amt_ext;
                                    state    <= INVULN;
                                    invuln_r <= 1'b1;
                                    cnt      <= CNT_W'(INVULN_CYC - 1);
                                end else begin
                                    hp     <= '0;
                                    state  <= DEAD;
                                    dead_r <= 1'b1;
                                end
                            end
                        end else if (heal_rise && hp < hp_max_c) begin
                            hp <= hp + HP_W'(1);
                        end
                    end
                    INVULN: begin
                        // counter runs INVULN_CYC-1 down to 0, one cycle each
                        if (cnt == '0) begin
                            state    <= ALIVE;
                            invuln_r <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                        if (!dmg_rise && heal_rise && hp < hp_max_c) begin
                            hp <= hp + HP_W'(1);
                        end
                    end
                    DEAD: begin
                        hp <= '0;
                    end
                    default: begin
                        state    <= ALIVE;
                        dead_r   <= 1'b0;
                        invuln_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.OUT_HP = hp;
    assign bus.DEAD   = dead_r;
    assign bus.INVULN = invuln_r;
    assign bus.HIT    = hit_r;

endmodule
